// File: rtl/iir_pkg.sv
// Shared types and helpers for the DF-I biquad: width rules for the product and
// accumulator datapath, plus the floor-shift-then-saturate used on every output.
package iir_pkg;

    typedef int signed coeff_int_t;

    localparam int unsigned WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int unsigned prod_width(input int unsigned cw, input int unsigned iw);
        return 2 * ((cw > iw) ? cw : iw);
    endfunction

    // Three guard bits cover the sum of five full-width products.
    function automatic int unsigned acc_width(input int unsigned cw, input int unsigned iw);
        return prod_width(cw, iw) + 3;
    endfunction

    function automatic wide_t sat_shift(input wide_t acc, input int unsigned shift,
                                        input int unsigned width);
        wide_t s;
        wide_t hi;
        wide_t lo;
        s  = acc >>> shift;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (width - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/iir_sat_shift.sv
// Combinational output stage: arithmetic (floor) shift of the accumulator and
// clamp to the signed sample range.
module iir_sat_shift
    import iir_pkg::*;
#(
    parameter int unsigned acc_w = 35,
    parameter int unsigned out_w = 16,
    parameter int unsigned shift = 14
) (
    input  logic signed [acc_w-1:0] acc,
    output logic signed [out_w-1:0] y
);

    assign y = out_w'(sat_shift(wide_t'(acc), shift, out_w));

endmodule

// File: rtl/iir_df1_biquad_axis.sv
// Direct-Form-I biquad with AXI4-Stream ports. One sample in flight at a time:
// register x, multiply, sum, then shift/saturate and update the feedback history.
module iir_df1_biquad_axis
    import iir_pkg::*;
#(
    parameter int unsigned coeff_width  = 16,
    parameter int unsigned inout_width  = 16,
    parameter int unsigned scale_factor = 14,
    parameter coeff_int_t  bo_int_coeff = 167,
    parameter coeff_int_t  b1_int_coeff = -302,
    parameter coeff_int_t  b2_int_coeff = 167,
    parameter coeff_int_t  a1_int_coeff = -31880,
    parameter coeff_int_t  a2_int_coeff = 15531
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_axis_tvalid,
    input  logic signed [inout_width-1:0] s_axis_tdata,
    output logic                          s_axis_tready,
    output logic signed [inout_width-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int unsigned prod_w = prod_width(coeff_width, inout_width);
    localparam int unsigned acc_w  = acc_width(coeff_width, inout_width);

    localparam logic signed [coeff_width-1:0] b0_c = coeff_width'(bo_int_coeff);
    localparam logic signed [coeff_width-1:0] b1_c = coeff_width'(b1_int_coeff);
    localparam logic signed [coeff_width-1:0] b2_c = coeff_width'(b2_int_coeff);
    localparam logic signed [coeff_width-1:0] a1_c = coeff_width'(a1_int_coeff);
    localparam logic signed [coeff_width-1:0] a2_c = coeff_width'(a2_int_coeff);

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_C1,
        ST_C2,
        ST_C3
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [inout_width-1:0] x_cur;
    logic signed [inout_width-1:0] x1;
    logic signed [inout_width-1:0] x2;
    logic signed [inout_width-1:0] y1;
    logic signed [inout_width-1:0] y2;
    logic signed [prod_w-1:0]      p_b0;
    logic signed [prod_w-1:0]      p_b1;
    logic signed [prod_w-1:0]      p_b2;
    logic signed [prod_w-1:0]      p_a1;
    logic signed [prod_w-1:0]      p_a2;
    logic signed [acc_w-1:0]       acc;
    logic signed [inout_width-1:0] y_sat;
    logic                          accept;

    // Both ports: a beat transfers on a rising edge where tvalid and tready are
    // both high. tready is low while a sample is in flight and input tvalid is
    // then ignored; output tvalid holds with data until taken, and a newer
    // result simply replaces an untaken one.
    assign s_axis_tready = (state == ST_IDLE);
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST:  state_next = ST_IDLE;
            ST_IDLE: if (s_axis_tvalid) state_next = ST_C1;
            ST_C1:   state_next = ST_C2;
            ST_C2:   state_next = ST_C3;
            ST_C3:   state_next = ST_IDLE;
            default: state_next = ST_RST;
        endcase
    end

    iir_sat_shift #(
        .acc_w (acc_w),
        .out_w (inout_width),
        .shift (scale_factor)
    ) u_sat_shift (
        .acc (acc),
        .y   (y_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cur         <= '0;
            x1            <= '0;
            x2            <= '0;
            y1            <= '0;
            y2            <= '0;
            p_b0          <= '0;
            p_b1          <= '0;
            p_b2          <= '0;
            p_a1          <= '0;
            p_a2          <= '0;
            acc           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (accept) begin
                x_cur <= s_axis_tdata;
            end
            if (state == ST_C1) begin
                p_b0 <= prod_w'(b0_c) * prod_w'(x_cur);
                p_b1 <= prod_w'(b1_c) * prod_w'(x1);
                p_b2 <= prod_w'(b2_c) * prod_w'(x2);
                p_a1 <= prod_w'(a1_c) * prod_w'(y1);
                p_a2 <= prod_w'(a2_c) * prod_w'(y2);
            end
            if (state == ST_C2) begin
                acc <= acc_w'(p_b0) + acc_w'(p_b1) + acc_w'(p_b2)
                     - acc_w'(p_a1) - acc_w'(p_a2);
            end
            // Feedback keeps the saturated value that actually leaves the block.
            if (state == ST_C3) begin
                x2            <= x1;
                x1            <= x_cur;
                y2            <= y1;
                y1            <= y_sat;
                m_axis_tdata  <= y_sat;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iir_df1_biquad_axis.sv
// Bench for the DF-I biquad: default-coefficient instance plus a high-gain
// instance for clamping, checked against a floor-divide/clamp reference model.
module tb_iir_df1_biquad_axis;

    logic clk;
    logic rst_n;

    logic               s_valid [2];
    logic signed [15:0] s_data  [2];
    logic               s_ready [2];
    logic signed [15:0] m_data  [2];
    logic               m_valid [2];
    logic               m_ready [2];

    int checks;
    int errors;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int          log0[$];
    int          log1[$];
    bit          latest_only0;
    logic [15:0] e0;
    logic [15:0] e1;

    int cb0 [2] = '{167, 30000};
    int cb1 [2] = '{-302, -30000};
    int cb2 [2] = '{167, 0};
    int ca1 [2] = '{-31880, 0};
    int ca2 [2] = '{15531, 0};
    int hx1 [2];
    int hx2 [2];
    int hy1 [2];
    int hy2 [2];

    iir_df1_biquad_axis dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_valid[0]),
        .s_axis_tdata  (s_data[0]),
        .s_axis_tready (s_ready[0]),
        .m_axis_tdata  (m_data[0]),
        .m_axis_tvalid (m_valid[0]),
        .m_axis_tready (m_ready[0])
    );

    iir_df1_biquad_axis #(
        .bo_int_coeff (30000),
        .b1_int_coeff (-30000),
        .b2_int_coeff (0),
        .a1_int_coeff (0),
        .a2_int_coeff (0)
    ) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_valid[1]),
        .s_axis_tdata  (s_data[1]),
        .s_axis_tready (s_ready[1]),
        .m_axis_tdata  (m_data[1]),
        .m_axis_tvalid (m_valid[1]),
        .m_axis_tready (m_ready[1])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // reference model: y = clamp(floor(sum / 2^14))
    function automatic void reset_model(input int w);
        hx1[w] = 0;
        hx2[w] = 0;
        hy1[w] = 0;
        hy2[w] = 0;
    endfunction

    function automatic int ref_step(input int w, input int x);
        longint sum;
        longint y;
        sum = longint'(cb0[w]) * x + longint'(cb1[w]) * hx1[w] + longint'(cb2[w]) * hx2[w]
            - longint'(ca1[w]) * hy1[w] - longint'(ca2[w]) * hy2[w];
        y = sum / 16384;
        if (sum < 0 && (sum % 16384) != 0) y = y - 1;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        hx2[w] = hx1[w];
        hx1[w] = x;
        hy2[w] = hy1[w];
        hy1[w] = int'(y);
        return int'(y);
    endfunction

    // driver
    task automatic send(input int w, input int x);
        bit done;
        done = 1'b0;
        @(negedge clk);
        s_data[w]  = 16'(x);
        s_valid[w] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (s_ready[w]) begin
                @(posedge clk);
                #1;
                s_valid[w] = 1'b0;
                if (w == 0) exp_q0.push_back(16'(ref_step(0, x)));
                else        exp_q1.push_back(16'(ref_step(1, x)));
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            s_valid[w] = 1'b0;
            chk("send_timeout", 0, 1);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
        end
        chk("drain_q0_left", exp_q0.size(), 0);
        chk("drain_q1_left", exp_q1.size(), 0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && m_valid[0] && m_ready[0]) begin
            if (exp_q0.size() == 0) begin
                chk("out0_unexpected", 1, 0);
            end else begin
                if (latest_only0) begin
                    e0 = exp_q0[$];
                    exp_q0.delete();
                end else begin
                    e0 = exp_q0.pop_front();
                end
                chk("out0_data", int'(m_data[0]), int'($signed(e0)));
                log0.push_back(int'(m_data[0]));
            end
        end
        if (rst_n && m_valid[1] && m_ready[1]) begin
            if (exp_q1.size() == 0) begin
                chk("out1_unexpected", 1, 0);
            end else begin
                e1 = exp_q1.pop_front();
                chk("out1_data", int'(m_data[1]), int'($signed(e1)));
                log1.push_back(int'(m_data[1]));
            end
        end
    end

    // stimulus
    initial begin
        int x;
        real ph;
        checks       = 0;
        errors       = 0;
        latest_only0 = 1'b0;
        rst_n        = 1'b0;
        for (int w = 0; w < 2; w++) begin
            s_valid[w] = 1'b0;
            s_data[w]  = '0;
            m_ready[w] = 1'b1;
            reset_model(w);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            chk("rst_tready", int'(s_ready[w]), 0);
            chk("rst_tvalid", int'(m_valid[w]), 0);
            chk("rst_tdata", int'(m_data[w]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_tready_low", int'(s_ready[0]), 0);
        @(posedge clk);
        #1;
        chk("rel_tready_high", int'(s_ready[0]), 1);

        // impulse with latency measurement on the first sample
        send(0, 32767);
        chk("lat_tready_c0", int'(s_ready[0]), 0);
        chk("lat_tvalid_c0", int'(m_valid[0]), 0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk("lat_tvalid", int'(m_valid[0]), (i == 3) ? 1 : 0);
            chk("lat_tready", int'(s_ready[0]), (i == 3) ? 1 : 0);
        end
        for (int i = 0; i < 12; i++) send(0, 0);
        drain();
        if (log0.size() >= 3) begin
            chk("imp_y0", log0[0], 333);
            chk("imp_y1", log0[1], 43);
            chk("imp_y2", log0[2], 101);
        end else begin
            chk("imp_count", log0.size(), 3);
        end

        // backpressure: results overwrite, history keeps advancing
        @(posedge clk);
        #1;
        m_ready[0]   = 1'b0;
        latest_only0 = 1'b1;
        for (int i = 0; i < 4; i++) send(0, int'($urandom_range(0, 20000)) - 10000);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_tvalid_held", int'(m_valid[0]), 1);
        chk("bp_latest", int'(m_data[0]), int'($signed(exp_q0[$])));
        m_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_tvalid_drop", int'(m_valid[0]), 0);
        latest_only0 = 1'b0;

        // random full-range stream with random gaps and occasional stalls
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(0, int'($urandom_range(0, 65535)) - 32768);
        end
        drain();

        // saturation on the high-gain instance
        for (int i = 0; i < 20; i++) send(1, (i % 2 == 0) ? 32767 : -32767);
        drain();
        if (log1.size() >= 2) begin
            chk("sat_pos", log1[0], 32767);
            chk("sat_neg", log1[1], -32768);
        end else begin
            chk("sat_count", log1.size(), 2);
        end

        // reset mid-computation
        send(0, 12345);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q0.delete();
        exp_q1.delete();
        reset_model(0);
        reset_model(1);
        chk("midrst_tvalid", int'(m_valid[0]), 0);
        chk("midrst_tready", int'(s_ready[0]), 0);
        chk("midrst_tdata", int'(m_data[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // noisy 50 kHz sine at 10 MHz: 200 samples per period
        for (int n = 0; n < 400; n++) begin
            ph = 2.0 * 3.14159265358979 * real'(n) / 200.0;
            x  = int'(20000.0 * $sin(ph)) + int'($urandom_range(0, 2000)) - 1000;
            send(0, x);
            if ((n % 4) == 0) send(1, x);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
